// File: rtl/multdiv_pkg.sv
// ============================================================================
// Module      : multdiv_pkg
// Description : Shared constants, state encoding and helpers for multdiv_unit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package multdiv_pkg;

    localparam int WIDTH = 32;
    localparam int ITERS = 32;
    localparam int CNT_W = 6;

    localparam logic [WIDTH-1:0] MD_INT_MIN = 32'h8000_0000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } md_state_t;

    // Magnitude of a two's complement value; INT_MIN maps to 2^31 as unsigned.
    function automatic logic [WIDTH-1:0] md_abs(input logic [WIDTH-1:0] v);
        return ((v & MD_INT_MIN) != '0) ? (~v + 1'b1) : v;
    endfunction

endpackage

`default_nettype wire

// File: rtl/md_iter_counter.sv
// ============================================================================
// Module      : md_iter_counter
// Description : Iteration counter with synchronous clear/enable; flags the
//               final step of an ITERS-long operation.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module md_iter_counter
    import multdiv_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_done
);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_done = (r_count == CNT_W'(ITERS - 1));

endmodule

`default_nettype wire

// File: rtl/multdiv_unit.sv
// ============================================================================
// Module      : multdiv_unit
// Description : Multi-cycle signed 32-bit Booth multiplier / restoring divider.
//               Optional macro MULTDIV_EARLY_DIV0_EN: zero-divisor divides
//               complete in one cycle instead of 32 iterations.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module multdiv_unit
    import multdiv_pkg::*;
(
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    input  logic             ctrl_MULT,
    input  logic             ctrl_DIV,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             op_is_div,
    output logic             data_resultRDY,
    output logic             busy
);

    md_state_t          r_state;
    logic [2*WIDTH:0]   r_booth;     // {acc, multiplier, q-1}
    logic [WIDTH-1:0]   r_mcand;
    logic [2*WIDTH-1:0] r_div;       // {remainder, quotient}
    logic [WIDTH-1:0]   r_dmag;
    logic               r_qneg;
    logic               r_div0;
    logic [WIDTH-1:0]   r_result;
    logic               r_exc;
    logic               r_op_div;
    logic               r_ready;
    logic               r_busy;

    logic               w_start;
    logic               w_iter_en;
    logic               w_last;
    logic [WIDTH:0]     w_acc_ext;
    logic [WIDTH:0]     w_sum;
    logic [2*WIDTH:0]   w_booth_next;
    logic [2*WIDTH-1:0] w_prod;
    logic               w_mul_ovf;
    logic [WIDTH:0]     w_partial;
    logic [WIDTH:0]     w_trial;
    logic [2*WIDTH-1:0] w_div_next;
    logic [WIDTH-1:0]   w_quo;
    logic [WIDTH-1:0]   w_div_res;

    assign w_start   = ctrl_MULT | ctrl_DIV;
    assign w_iter_en = (r_state == MUL) || (r_state == DIV);

    md_iter_counter u_iter_counter (
        .clk      (clock),
        .rst      (reset),
        .i_clear  (w_start),
        .i_enable (w_iter_en),
        .o_done   (w_last)
    );

    // Booth step: add/sub in 33 bits so the shifted-in sign is always correct,
    // even when the multiplicand is INT_MIN.
    always_comb begin
        w_acc_ext = {r_booth[2*WIDTH], r_booth[2*WIDTH:WIDTH+1]};
        w_sum     = w_acc_ext;
        case (r_booth[1:0])
            2'b01:   w_sum = w_acc_ext + {r_mcand[WIDTH-1], r_mcand};
            2'b10:   w_sum = w_acc_ext - {r_mcand[WIDTH-1], r_mcand};
            default: w_sum = w_acc_ext;
        endcase
    end

    assign w_booth_next = {w_sum, r_booth[WIDTH:1]};
    assign w_prod       = w_booth_next[2*WIDTH:1];
    assign w_mul_ovf    = (w_prod[2*WIDTH-1:WIDTH] != {WIDTH{w_prod[WIDTH-1]}});

    // Restoring step on magnitudes; the shifted remainder never exceeds 32 bits.
    assign w_partial  = r_div[2*WIDTH-1:WIDTH-1];
    assign w_trial    = w_partial - {1'b0, r_dmag};
    assign w_div_next = w_trial[WIDTH] ? {r_div[2*WIDTH-2:0], 1'b0}
                                       : {w_trial[WIDTH-1:0], r_div[WIDTH-2:0], 1'b1};
    assign w_quo      = w_div_next[WIDTH-1:0];
    assign w_div_res  = r_div0 ? '0 : (r_qneg ? (~w_quo + 1'b1) : w_quo);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state  <= IDLE;
            r_booth  <= '0;
            r_mcand  <= '0;
            r_div    <= '0;
            r_dmag   <= '0;
            r_qneg   <= 1'b0;
            r_div0   <= 1'b0;
            r_result <= '0;
            r_exc    <= 1'b0;
            r_op_div <= 1'b0;
            r_ready  <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            r_ready <= 1'b0;
            if (ctrl_MULT) begin
                r_state <= MUL;
                r_busy  <= 1'b1;
                r_booth <= {{WIDTH{1'b0}}, data_operandA, 1'b0};
                r_mcand <= data_operandB;
            end else if (ctrl_DIV) begin
                r_busy <= 1'b1;
                r_div  <= {{WIDTH{1'b0}}, md_abs(data_operandA)};
                r_dmag <= md_abs(data_operandB);
                r_qneg <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
                r_div0 <= (data_operandB == '0);
`ifdef MULTDIV_EARLY_DIV0_EN
                if (data_operandB == '0) begin
                    r_state  <= DONE;
                    r_result <= '0;
                    r_exc    <= 1'b1;
                    r_op_div <= 1'b1;
                    r_ready  <= 1'b1;
                end else begin
                    r_state <= DIV;
                end
`else
                r_state <= DIV;
`endif
            end else begin
                case (r_state)
                    MUL: begin
                        r_booth <= w_booth_next;
                        if (w_last) begin
                            r_state  <= DONE;
                            r_result <= w_prod[WIDTH-1:0];
                            r_exc    <= w_mul_ovf;
                            r_op_div <= 1'b0;
                            r_ready  <= 1'b1;
                        end
                    end
                    DIV: begin
                        r_div <= w_div_next;
                        if (w_last) begin
                            r_state  <= DONE;
                            r_result <= w_div_res;
                            r_exc    <= r_div0;
                            r_op_div <= 1'b1;
                            r_ready  <= 1'b1;
                        end
                    end
                    DONE: begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end
                    default: begin
                        r_state <= IDLE;
                    end
                endcase
            end
        end
    end

    assign data_result    = r_result;
    assign data_exception = r_exc;
    assign op_is_div      = r_op_div;
    assign data_resultRDY = r_ready;
    assign busy           = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_multdiv_unit.sv
// ============================================================================
// Module      : tb_multdiv_unit
// Description : Self-checking bench for multdiv_unit: directed cases plus
//               randomized starts compared against a cycle-level reference.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_multdiv_unit;

`ifdef MULTDIV_EARLY_DIV0_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif
    localparam int DIV0_LAT = EARLY ? 1 : 33;
    localparam logic [31:0] INT_MIN = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] data_operandA = '0;
    logic [31:0] data_operandB = '0;
    logic        ctrl_MULT = 1'b0;
    logic        ctrl_DIV = 1'b0;
    logic [31:0] data_result;
    logic        data_exception;
    logic        op_is_div;
    logic        data_resultRDY;
    logic        busy;

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    multdiv_unit dut (
        .clock          (clk),
        .reset          (rst),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .ctrl_MULT      (ctrl_MULT),
        .ctrl_DIV       (ctrl_DIV),
        .data_result    (data_result),
        .data_exception (data_exception),
        .op_is_div      (op_is_div),
        .data_resultRDY (data_resultRDY),
        .busy           (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference arithmetic: returns {exception, result}.
    function automatic logic [32:0] ref_op(input bit is_mul, input logic [31:0] a, input logic [31:0] b);
        longint p;
        logic [31:0] lo;
        int sa;
        int sb;
        int q;
        if (is_mul) begin
            p  = longint'($signed(a)) * longint'($signed(b));
            lo = p[31:0];
            return {p != longint'($signed(lo)), lo};
        end
        if (b == 32'd0) return {1'b1, 32'd0};
        if (a == INT_MIN && b == 32'hFFFF_FFFF) return {1'b0, INT_MIN};
        sa = a;
        sb = b;
        q  = sa / sb;
        return {1'b0, 32'(q)};
    endfunction

    // Cycle-level expectation: countdown to ready, held result registers.
    logic        m_ready, m_busy, m_exc, m_div, p_exc, p_div;
    logic [31:0] m_res, p_res;
    int          m_rem;
    logic [32:0] w_ref;
    assign w_ref = ref_op(ctrl_MULT, data_operandA, data_operandB);

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_ready <= 0; m_busy <= 0; m_exc <= 0; m_div <= 0; m_res <= '0; m_rem <= 0;
        end else if (ctrl_MULT || ctrl_DIV) begin
            m_busy <= 1;
            if (EARLY && !ctrl_MULT && data_operandB == 32'd0) begin
                m_rem <= 0; m_ready <= 1; m_res <= '0; m_exc <= 1; m_div <= 1;
            end else begin
                m_rem <= 32; m_ready <= 0;
                p_res <= w_ref[31:0]; p_exc <= w_ref[32]; p_div <= !ctrl_MULT;
            end
        end else if (m_rem > 1) begin
            m_rem <= m_rem - 1; m_ready <= 0;
        end else if (m_rem == 1) begin
            m_rem <= 0; m_ready <= 1; m_res <= p_res; m_exc <= p_exc; m_div <= p_div;
        end else begin
            m_busy <= 0; m_ready <= 0;
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            check("ready", 32'(data_resultRDY), 32'(m_ready));
            check("busy", 32'(busy), 32'(m_busy));
            check("result", data_result, m_res);
            check("exception", 32'(data_exception), 32'(m_exc));
            check("op_is_div", 32'(op_is_div), 32'(m_div));
        end
    end

    task automatic run_op(input bit now, input bit m, input bit d, input logic [31:0] a,
                          input logic [31:0] b, input int exp_lat, input logic [31:0] exp_res,
                          input bit exp_exc, input bit exp_div, input string name);
        int c0;
        bit seen;
        if (!now) @(negedge clk);
        ctrl_MULT = m; ctrl_DIV = d; data_operandA = a; data_operandB = b;
        c0 = cyc;
        seen = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (k == 1) begin ctrl_MULT = 0; ctrl_DIV = 0; end
            if (data_resultRDY) begin seen = 1; break; end
        end
        check({name, " ready seen"}, 32'(seen), 32'd1);
        if (seen) begin
            check({name, " latency"}, 32'(cyc - c0), 32'(exp_lat));
            check({name, " result"}, data_result, exp_res);
            check({name, " exception"}, 32'(data_exception), 32'(exp_exc));
            check({name, " op_is_div"}, 32'(op_is_div), 32'(exp_div));
        end
    endtask

    function automatic logic [31:0] rand_operand();
        case ($urandom_range(0, 7))
            0: return 32'd0;
            1: return INT_MIN;
            2: return 32'hFFFF_FFFF;
            3: return 32'($urandom_range(0, 20));
            4: return 32'(-$urandom_range(1, 20));
            default: return 32'($urandom);
        endcase
    endfunction

    initial begin
        int n_rdy;
        int lat;
        int c0;
        logic [31:0] res;

        #1;
        check("reset result", data_result, 32'd0);
        check("reset ready", 32'(data_resultRDY), 32'd0);
        check("reset busy", 32'(busy), 32'd0);
        check("reset exception", 32'(data_exception), 32'd0);
        check("reset op_is_div", 32'(op_is_div), 32'd0);
        repeat (2) @(negedge clk);
        rst = 0;

        run_op(0, 1, 0, 32'd7, 32'hFFFF_FFFD, 33, 32'hFFFF_FFEB, 0, 0, "mul 7*-3");
        run_op(0, 1, 0, 32'h0001_0000, 32'h0001_0000, 33, 32'h0, 1, 0, "mul ovf");
        run_op(0, 1, 0, INT_MIN, 32'hFFFF_FFFF, 33, INT_MIN, 1, 0, "mul min*-1");
        run_op(0, 0, 1, 32'hFFFF_FFEF, 32'd5, 33, 32'hFFFF_FFFD, 0, 1, "div -17/5");
        run_op(0, 0, 1, INT_MIN, 32'hFFFF_FFFF, 33, INT_MIN, 0, 1, "div min/-1");
        run_op(0, 0, 1, 32'd100, 32'd0, DIV0_LAT, 32'd0, 1, 1, "div by zero");
        run_op(0, 1, 1, 32'd6, 32'd7, 33, 32'd42, 0, 0, "mult+div both");
        run_op(1, 0, 1, 32'd9, 32'd2, 33, 32'd4, 0, 1, "back-to-back div");

        // Abort: a divide started ten cycles into a multiply replaces it.
        @(negedge clk);
        ctrl_MULT = 1; data_operandA = 32'd6; data_operandB = 32'd7;
        c0 = cyc; n_rdy = 0; lat = 0; res = '0;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            if (k == 1) ctrl_MULT = 0;
            if (k == 10) begin ctrl_DIV = 1; data_operandA = 32'd9; data_operandB = 32'd2; end
            if (k == 11) ctrl_DIV = 0;
            if (data_resultRDY) begin n_rdy++; lat = cyc - c0; res = data_result; end
        end
        check("abort ready count", 32'(n_rdy), 32'd1);
        check("abort latency", 32'(lat), 32'd43);
        check("abort result", res, 32'd4);

        // Asynchronous reset in the middle of a divide.
        @(negedge clk);
        ctrl_DIV = 1; data_operandA = 32'hFFFF_FF9C; data_operandB = 32'd7;
        for (int k = 1; k <= 15; k++) begin
            @(negedge clk);
            if (k == 1) ctrl_DIV = 0;
        end
        #2 rst = 1;
        #1;
        check("mid reset result", data_result, 32'd0);
        check("mid reset ready", 32'(data_resultRDY), 32'd0);
        check("mid reset busy", 32'(busy), 32'd0);
        check("mid reset exception", 32'(data_exception), 32'd0);
        check("mid reset op_is_div", 32'(op_is_div), 32'd0);
        @(negedge clk);
        #2 rst = 0;
        n_rdy = 0;
        for (int k = 0; k < 45; k++) begin
            @(negedge clk);
            if (data_resultRDY) n_rdy++;
        end
        check("no ready after reset", 32'(n_rdy), 32'd0);
        run_op(0, 1, 0, 32'd6, 32'd7, 33, 32'd42, 0, 0, "mul after reset");

        // Random starts, aborts and back-to-back ops against the reference.
        for (int k = 0; k < 6000; k++) begin
            @(negedge clk);
            ctrl_MULT = 0; ctrl_DIV = 0;
            data_operandA = rand_operand();
            data_operandB = rand_operand();
            if ($urandom_range(0, 59) == 0 || (data_resultRDY && $urandom_range(0, 3) == 0)) begin
                case ($urandom_range(0, 2))
                    0: ctrl_MULT = 1;
                    1: ctrl_DIV = 1;
                    default: begin ctrl_MULT = 1; ctrl_DIV = 1; end
                endcase
            end
        end
        @(negedge clk);
        ctrl_MULT = 0; ctrl_DIV = 0;
        repeat (40) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
